// File: rtl/fsm_1.sv
`default_nettype none
// ============================================================================
// Module      : fsm_1
// Description : Moore detector for the serial pattern 1,1,1,0 (overlapping).
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_1 (
    input  wire  clk,
    input  wire  rst,
    input  wire  inp,
    output logic outp
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    logic [2:0] state;
    logic [2:0] state_d;

    // rst is active-low and asynchronous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        case (state)
            S0:      state_d = inp ? S1 : S0;
            S1:      state_d = inp ? S2 : S0;
            S2:      state_d = inp ? S3 : S0;
            S3:      state_d = inp ? S3 : S4;
            S4:      state_d = inp ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    // Decoded from state only; inp never reaches outp combinationally.
    always_comb begin
        outp = 1'b0;
        if (state == S4) begin
            outp = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_1
// Description : Scoreboard bench for the 1110 Moore detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_1;

    logic clk;
    logic rst;
    logic inp;
    logic outp;

    int vectors;
    int miscompares;

    typedef struct {
        logic [2:0] st;
        logic       o;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    fsm_1 dut (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .outp (outp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [2:0] act_s, input logic [2:0] exp_s,
                         input logic act_o, input logic exp_o);
        vectors++;
        if (act_s !== exp_s || act_o !== exp_o) begin
            miscompares++;
            $display("FAIL %s: actual state=%0d outp=%b, required state=%0d outp=%b",
                     name, act_s, act_o, exp_s, exp_o);
        end
    endtask

    // Monitor: compares each posted expectation one step after the edge it belongs to.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, dut.state, e.st, outp, e.o);
            end
        end
    end

    task automatic apply(input logic b, input logic [2:0] st, input logic o, input string name);
        exp_t e;
        @(negedge clk);
        inp = b;
        e.st = st;
        e.o = o;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [2:0] short_st [5];
        logic       short_in [5];
        logic [2:0] b2b_st   [8];
        logic       b2b_in   [8];
        vectors = 0;
        miscompares = 0;
        inp = 1'b0;
        rst = 1'b0;

        // Reset before any clock edge.
        #1;
        check("reset_no_clk", dut.state, 3'd0, outp, 1'b0);
        @(posedge clk);
        #1;
        check("reset_with_clk", dut.state, 3'd0, outp, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Long run: 0, fourteen 1s, 0.
        apply(1'b0, 3'd0, 1'b0, "long_0");
        for (int i = 1; i <= 14; i++) begin
            apply(1'b1, (i >= 3) ? 3'd3 : 3'(i), 1'b0, $sformatf("long_1_%0d", i));
        end
        apply(1'b0, 3'd4, 1'b1, "long_end");

        // Short runs from S4: 1,1,0,1,0.
        short_in = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        short_st = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            apply(short_in[i], short_st[i], 1'b0, $sformatf("short_%0d", i));
        end

        // Back-to-back detections.
        b2b_in = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        b2b_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 8; i++) begin
            apply(b2b_in[i], b2b_st[i], (b2b_st[i] == 3'd4), $sformatf("b2b_%0d", i));
        end
        drain();

        // Asynchronous reset while in S4.
        rst = 1'b0;
        #1;
        check("reset_in_s4", dut.state, 3'd0, outp, 1'b0);
        #1;
        rst = 1'b1;

        // Mid-pattern reset after 1,1,1 then a 0.
        apply(1'b1, 3'd1, 1'b0, "mid_1a");
        apply(1'b1, 3'd2, 1'b0, "mid_1b");
        apply(1'b1, 3'd3, 1'b0, "mid_1c");
        drain();
        rst = 1'b0;
        #1;
        check("mid_reset_pulse", dut.state, 3'd0, outp, 1'b0);
        #1;
        rst = 1'b1;
        apply(1'b0, 3'd0, 1'b0, "mid_after_0");
        drain();

        // Unused encodings recover to S0 on the next edge.
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            inp = 1'b0;
            force dut.state = 3'(k);
            #1;
            check($sformatf("illegal_%0d_hold", k), dut.state_d, 3'd0, outp, 1'b0);
            release dut.state;
            @(posedge clk);
            #1;
            check($sformatf("illegal_%0d_next", k), dut.state, 3'd0, outp, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
